// File: rtl/proc_loader.sv
// Serial load/run master for the processor's chip-select + shift-buffer port.
// Shifts 12-bit {data,addr} frames LSB first, commits them, and supervises runs.
module proc_loader #(
  parameter int unsigned RUN_MAX = 1023,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_in,
  output logic             cmd_ready_out,
  input  logic [1:0]       cmd_op_in,
  input  logic [3:0]       cmd_addr_in,
  input  logic [7:0]       cmd_data_in,
  input  logic             proc_done_in,
  output logic [1:0]       sel_out,
  output logic             mosi_out,
  output logic             busy_out,
  output logic             run_done_out,
  output logic             run_timeout_out,
  output logic [CNT_W-1:0] run_cycles_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, RUN} state_t;

  state_t           state, state_nxt;
  logic [10:0]      shreg;
  logic [3:0]       bit_cnt;
  logic [1:0]       sel_q;
  logic             mosi_q;
  logic             started;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_nxt;
  logic             run_done_q;
  logic             run_timeout_q;
  logic             accept;
  logic             run_stop;
  logic             run_to;
  logic             last_bit;

  always_comb begin
    accept    = cmd_valid_in && (state == IDLE);
    last_bit  = (bit_cnt == 4'd11);
    cnt_inc   = (run_cnt == '1) ? run_cnt : run_cnt + CNT_W'(1);
    cnt_nxt   = proc_done_in ? run_cnt : cnt_inc;
    run_stop  = started && proc_done_in;
    run_to    = !run_stop && (cnt_nxt >= CNT_W'(RUN_MAX));
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op_in)
            2'b00, 2'b01: state_nxt = SHIFT;
            2'b10:        state_nxt = RUN;
            default:      state_nxt = IDLE;
          endcase
        end
      end
      SHIFT:   if (last_bit) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      RUN:     if (run_stop || run_to) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg         <= '0;
      bit_cnt       <= '0;
      sel_q         <= '0;
      mosi_q        <= 1'b0;
      started       <= 1'b0;
      run_cnt       <= '0;
      run_done_q    <= 1'b0;
      run_timeout_q <= 1'b0;
    end else begin
      run_done_q    <= 1'b0;
      run_timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (cmd_op_in)
              2'b00, 2'b01: begin
                // Bit 0 goes straight to mosi; the remaining 11 bits wait in shreg.
                shreg   <= {cmd_data_in, cmd_addr_in[3:1]};
                mosi_q  <= cmd_addr_in[0];
                bit_cnt <= '0;
                sel_q   <= (cmd_op_in == 2'b00) ? 2'b01 : 2'b10;
              end
              2'b10: begin
                sel_q   <= 2'b11;
                run_cnt <= '0;
                started <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        SHIFT: begin
          if (last_bit) begin
            sel_q   <= '0;
            mosi_q  <= 1'b0;
            bit_cnt <= '0;
          end else begin
            mosi_q  <= shreg[0];
            shreg   <= {1'b0, shreg[10:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        RUN: begin
          run_cnt <= cnt_nxt;
          if (!proc_done_in) started <= 1'b1;
          if (run_stop || run_to) begin
            sel_q         <= '0;
            run_done_q    <= 1'b1;
            run_timeout_q <= run_to;
          end
        end
        default: ;
      endcase
    end
  end

  // Done rising must drop run-enable in that same cycle, so this path is combinational.
  assign sel_out         = (state == RUN && run_stop) ? 2'b00 : sel_q;
  assign mosi_out        = mosi_q;
  assign cmd_ready_out   = (state == IDLE);
  assign busy_out        = (state != IDLE);
  assign run_done_out    = run_done_q;
  assign run_timeout_out = run_timeout_q;
  assign run_cycles_out  = run_cnt;

endmodule

// File: tb/tb_proc_loader.sv
// Directed bench for proc_loader: frame serialisation, back-to-back writes,
// normal and timed-out runs, reserved op and reset mid-frame.
module tb_proc_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_in = 1'b0;
  logic        cmd_ready_out;
  logic [1:0]  cmd_op_in = 2'b00;
  logic [3:0]  cmd_addr_in = 4'h0;
  logic [7:0]  cmd_data_in = 8'h00;
  logic        proc_done_in = 1'b1;
  logic [1:0]  sel_out;
  logic        mosi_out;
  logic        busy_out;
  logic        run_done_out;
  logic        run_timeout_out;
  logic [15:0] run_cycles_out;

  int vectors = 0;
  int errors  = 0;

  proc_loader #(.RUN_MAX(100), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_op_in(cmd_op_in), .cmd_addr_in(cmd_addr_in), .cmd_data_in(cmd_data_in),
    .proc_done_in(proc_done_in),
    .sel_out(sel_out), .mosi_out(mosi_out), .busy_out(busy_out),
    .run_done_out(run_done_out), .run_timeout_out(run_timeout_out),
    .run_cycles_out(run_cycles_out)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid_in = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    #1;
    vectors++; if (sel_out !== 2'b00) begin errors++; $display("FAIL reset_sel: got %b want 00", sel_out); end
    vectors++; if (mosi_out !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi_out); end
    vectors++; if (cmd_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready_out); end
    vectors++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_out); end
    vectors++; if ({run_done_out, run_timeout_out} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {run_done_out, run_timeout_out}); end
    vectors++; if (run_cycles_out !== 16'd0) begin errors++; $display("FAIL reset_cycles: got %0d want 0", run_cycles_out); end
  endtask

  task automatic test_instr_write();
    bit exp_seq [12];
    exp_seq = '{1,1,0,0,1,0,1,0,0,1,0,1};
    cmd_op_in = 2'b00; cmd_addr_in = 4'h3; cmd_data_in = 8'hA5; cmd_valid_in = 1'b1;
    cyc();
    cmd_valid_in = 1'b0;
    #1;
    for (int k = 0; k < 12; k++) begin
      vectors++; if (sel_out !== 2'b01) begin errors++; $display("FAIL iw_sel[%0d]: got %b want 01", k, sel_out); end
      vectors++; if (mosi_out !== exp_seq[k]) begin errors++; $display("FAIL iw_mosi[%0d]: got %b want %b", k, mosi_out, exp_seq[k]); end
      vectors++; if (cmd_ready_out !== 1'b0) begin errors++; $display("FAIL iw_ready[%0d]: got %b want 0", k, cmd_ready_out); end
      cyc(); #1;
    end
    vectors++; if (sel_out !== 2'b00) begin errors++; $display("FAIL iw_commit_sel: got %b want 00", sel_out); end
    vectors++; if (busy_out !== 1'b1) begin errors++; $display("FAIL iw_commit_busy: got %b want 1", busy_out); end
    vectors++; if (cmd_ready_out !== 1'b0) begin errors++; $display("FAIL iw_commit_ready: got %b want 0", cmd_ready_out); end
    cyc(); #1;
    vectors++; if (cmd_ready_out !== 1'b1) begin errors++; $display("FAIL iw_idle_ready: got %b want 1", cmd_ready_out); end
    vectors++; if (busy_out !== 1'b0) begin errors++; $display("FAIL iw_idle_busy: got %b want 0", busy_out); end
  endtask

  task automatic test_back_to_back();
    bit e1 [12];
    bit e2 [12];
    logic [1:0] exp_sel;
    logic       exp_mosi;
    logic       exp_ready;
    e1 = '{1,1,1,1,1,0,0,0,0,0,0,1};
    e2 = '{0,0,0,0,0,1,1,1,1,1,1,0};
    cmd_op_in = 2'b01; cmd_addr_in = 4'hF; cmd_data_in = 8'h81; cmd_valid_in = 1'b1;
    cyc();
    cmd_addr_in = 4'h0; cmd_data_in = 8'h7E;
    #1;
    for (int c = 1; c <= 27; c++) begin
      exp_sel   = ((c >= 1 && c <= 12) || (c >= 15 && c <= 26)) ? 2'b10 : 2'b00;
      exp_mosi  = (c <= 12) ? e1[c-1] : ((c >= 15 && c <= 26) ? e2[c-15] : 1'b0);
      exp_ready = (c == 14);
      vectors++; if (sel_out !== exp_sel) begin errors++; $display("FAIL b2b_sel[%0d]: got %b want %b", c, sel_out, exp_sel); end
      vectors++; if (mosi_out !== exp_mosi) begin errors++; $display("FAIL b2b_mosi[%0d]: got %b want %b", c, mosi_out, exp_mosi); end
      vectors++; if (cmd_ready_out !== exp_ready) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", c, cmd_ready_out, exp_ready); end
      cyc();
      if (c == 14) cmd_valid_in = 1'b0;
      #1;
    end
  endtask

  task automatic test_run_normal();
    cmd_op_in = 2'b10; cmd_valid_in = 1'b1;
    cyc();
    cmd_valid_in = 1'b0;
    #1;
    vectors++; if (sel_out !== 2'b11) begin errors++; $display("FAIL run_first_sel: got %b want 11", sel_out); end
    vectors++; if (busy_out !== 1'b1) begin errors++; $display("FAIL run_first_busy: got %b want 1", busy_out); end
    cyc();
    proc_done_in = 1'b0;
    #1;
    for (int k = 0; k < 16; k++) begin
      vectors++; if (sel_out !== 2'b11) begin errors++; $display("FAIL run_sel[%0d]: got %b want 11", k, sel_out); end
      vectors++; if (run_done_out !== 1'b0) begin errors++; $display("FAIL run_early_done[%0d]: got %b want 0", k, run_done_out); end
      cyc();
      if (k == 15) proc_done_in = 1'b1;
      #1;
    end
    vectors++; if (sel_out !== 2'b00) begin errors++; $display("FAIL run_rise_sel: got %b want 00", sel_out); end
    vectors++; if (run_done_out !== 1'b0) begin errors++; $display("FAIL run_rise_done: got %b want 0", run_done_out); end
    cyc(); #1;
    vectors++; if (run_done_out !== 1'b1) begin errors++; $display("FAIL run_done_pulse: got %b want 1", run_done_out); end
    vectors++; if (run_timeout_out !== 1'b0) begin errors++; $display("FAIL run_timeout: got %b want 0", run_timeout_out); end
    vectors++; if (run_cycles_out !== 16'd16) begin errors++; $display("FAIL run_cycles: got %0d want 16", run_cycles_out); end
    vectors++; if (busy_out !== 1'b0) begin errors++; $display("FAIL run_end_busy: got %b want 0", busy_out); end
    vectors++; if (sel_out !== 2'b00) begin errors++; $display("FAIL run_end_sel: got %b want 00", sel_out); end
    cyc(); #1;
    vectors++; if (run_done_out !== 1'b0) begin errors++; $display("FAIL run_done_width: got %b want 0", run_done_out); end
    vectors++; if (run_cycles_out !== 16'd16) begin errors++; $display("FAIL run_cycles_hold: got %0d want 16", run_cycles_out); end
  endtask

  task automatic test_run_timeout();
    cmd_op_in = 2'b10; cmd_valid_in = 1'b1;
    cyc();
    cmd_valid_in = 1'b0;
    #1;
    vectors++; if (run_cycles_out !== 16'd0) begin errors++; $display("FAIL to_clear_cycles: got %0d want 0", run_cycles_out); end
    cyc();
    proc_done_in = 1'b0;
    #1;
    for (int k = 1; k <= 100; k++) begin
      vectors++; if (sel_out !== 2'b11) begin errors++; $display("FAIL to_sel[%0d]: got %b want 11", k, sel_out); end
      vectors++; if (run_done_out !== 1'b0) begin errors++; $display("FAIL to_early_done[%0d]: got %b want 0", k, run_done_out); end
      cyc(); #1;
    end
    vectors++; if (run_done_out !== 1'b1) begin errors++; $display("FAIL to_done: got %b want 1", run_done_out); end
    vectors++; if (run_timeout_out !== 1'b1) begin errors++; $display("FAIL to_timeout: got %b want 1", run_timeout_out); end
    vectors++; if (run_cycles_out !== 16'd100) begin errors++; $display("FAIL to_cycles: got %0d want 100", run_cycles_out); end
    vectors++; if (sel_out !== 2'b00) begin errors++; $display("FAIL to_sel_after: got %b want 00", sel_out); end
    vectors++; if (busy_out !== 1'b0) begin errors++; $display("FAIL to_busy: got %b want 0", busy_out); end
    proc_done_in = 1'b1;
    #1;
    vectors++; if (sel_out !== 2'b00) begin errors++; $display("FAIL to_sel_done: got %b want 00", sel_out); end
    cyc(); #1;
    vectors++; if ({run_done_out, run_timeout_out} !== 2'b00) begin errors++; $display("FAIL to_pulse_width: got %b want 00", {run_done_out, run_timeout_out}); end
  endtask

  task automatic test_reserved();
    cmd_op_in = 2'b11; cmd_valid_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++; if (cmd_ready_out !== 1'b1) begin errors++; $display("FAIL rsv_ready[%0d]: got %b want 1", k, cmd_ready_out); end
      vectors++; if (busy_out !== 1'b0) begin errors++; $display("FAIL rsv_busy[%0d]: got %b want 0", k, busy_out); end
      vectors++; if (sel_out !== 2'b00) begin errors++; $display("FAIL rsv_sel[%0d]: got %b want 00", k, sel_out); end
      vectors++; if (run_done_out !== 1'b0) begin errors++; $display("FAIL rsv_done[%0d]: got %b want 0", k, run_done_out); end
      cyc();
    end
    cmd_valid_in = 1'b0;
    #1;
    vectors++; if (run_cycles_out !== 16'd100) begin errors++; $display("FAIL rsv_cycles: got %0d want 100", run_cycles_out); end
  endtask

  task automatic test_reset_mid_shift();
    cmd_op_in = 2'b00; cmd_addr_in = 4'hF; cmd_data_in = 8'h00; cmd_valid_in = 1'b1;
    cyc();
    cmd_valid_in = 1'b0;
    cyc(); cyc(); cyc();
    #1;
    vectors++; if ({sel_out, mosi_out} !== 3'b011) begin errors++; $display("FAIL mid_pre: got %b want 011", {sel_out, mosi_out}); end
    rst_n = 1'b0;
    cyc(); #1;
    vectors++; if (sel_out !== 2'b00) begin errors++; $display("FAIL mid_rst_sel: got %b want 00", sel_out); end
    vectors++; if (busy_out !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy_out); end
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); #1;
    vectors++; if (sel_out !== 2'b00) begin errors++; $display("FAIL mid_rel_sel: got %b want 00", sel_out); end
    vectors++; if (mosi_out !== 1'b0) begin errors++; $display("FAIL mid_rel_mosi: got %b want 0", mosi_out); end
    vectors++; if (cmd_ready_out !== 1'b1) begin errors++; $display("FAIL mid_rel_ready: got %b want 1", cmd_ready_out); end
    vectors++; if (run_cycles_out !== 16'd0) begin errors++; $display("FAIL mid_rel_cycles: got %0d want 0", run_cycles_out); end
    cyc(); #1;
    vectors++; if ({sel_out, busy_out} !== 3'b000) begin errors++; $display("FAIL mid_no_resume: got %b want 000", {sel_out, busy_out}); end
  endtask

  initial begin
    test_reset();
    test_instr_write();
    test_back_to_back();
    test_run_normal();
    test_run_timeout();
    test_reserved();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/proc_loader.md
# proc_loader

SPI-style master that drives the processor's serial load/run port from a host-side command interface. It serialises 12-bit frames (4-bit address + 8-bit data) into the instruction or data memory, starts execution and waits for completion. It sits between a host/testbench source and the processor's `uio_in[2:0]` / `uio_out[3]` pins, mirroring the processor's chip-select and shift-buffer protocol from the master side.

## Interface

Parameters:
- `RUN_MAX` (default 1023): maximum number of cycles a run may hold the processor busy before it is forcibly stopped.
- `CNT_W` (default 16): width of the run-cycle counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset. The processor shares the same `rst_n`.
- `cmd_valid_in`  in  1  command valid.
- `cmd_ready_out`  out  1  command accepted when `cmd_valid_in & cmd_ready_out`.
- `cmd_op_in`  in  2  operation: 00 = instruction write, 01 = data write, 10 = run, 11 = reserved (accepted, no-op).
- `cmd_addr_in`  in  4  memory address, used by writes.
- `cmd_data_in`  in  8  memory data, used by writes.
- `proc_done_in`  in  1  processor done/idle flag, from `uio_out[3]`.
- `sel_out`  out  2  drives `uio_in[1:0]`: 00 = idle, 01 = instruction select, 10 = data select, 11 = run enable.
- `mosi_out`  out  1  serial data, drives `uio_in[2]`.
- `busy_out`  out  1  high in every state except IDLE.
- `run_done_out`  out  1  one-cycle pulse when a run ends.
- `run_timeout_out`  out  1  one-cycle pulse, coincident with `run_done_out`, when the run was ended by `RUN_MAX`.
- `run_cycles_out`  out  CNT_W  number of cycles `proc_done_in` was low in the last run. Saturates at all-ones.

## Operation

- States: IDLE, SHIFT, COMMIT, RUN.
- Reset values: state IDLE, `sel_out`=00, `mosi_out`=0, `cmd_ready_out`=1, `busy_out`=0, pulses 0, `run_cycles_out`=0, bit counter 0.
- `cmd_ready_out` = (state==IDLE).
- Frame on accept of op 00/01:
  - Latch the frame as `{data, addr}`.
  - Go to SHIFT with `sel_out`=01 (op 00) or 10 (op 01).
  - Bits are sent LSB first: addr[0..3], then data[0..7], one bit per cycle.
  - This matches the processor buffer, where new bits enter at the MSB and the first bit lands at bit 0.
- SHIFT lasts exactly 12 cycles. `sel_out` and `mosi_out` are registered and stable for the whole cycle.
- COMMIT: one cycle with `sel_out`=00. The processor writes its buffer into memory on this cycle. Then go to IDLE.
- Run on accept of op 10:
  - Go to RUN and clear the counter and the `started` flag.
  - `sel_out` = 11 while in RUN, except when `started & proc_done_in`, where it is forced to 00. This is the only combinational input-to-output path.
  - It prevents the processor re-entering execution on the cycle done rises.
- In RUN, `started` sets on the first cycle `proc_done_in`==0. `run_cycles_out` increments on each cycle `proc_done_in`==0.
- RUN ends, going to IDLE and pulsing `run_done_out`, when either:
  - `started & proc_done_in`, or
  - the cycle count reaches `RUN_MAX`. In that case also pulse `run_timeout_out`; `sel_out` is 00 from the next cycle.
- Reserved op 11: accepted, no state change, no pulse.
- The processor clears its instruction memory after a run that reaches the last address. The host must reload the program before the next run. No special handling is done here.
- Reset mid-operation: return to reset values on the next edge, with no frame completion. A partial frame is harmless only because the processor is reset simultaneously.

## Timing

- Write accepted at edge T:
  - `sel_out` = 01/10 during cycles T+1..T+12, with `mosi_out` = bit k in cycle T+1+k.
  - `sel_out` = 00 at T+13 (COMMIT).
  - `cmd_ready_out` = 1 at T+14.
- Back-to-back writes: the next accept is at T+14 at the earliest, so frames are 14 cycles apart with 2 select-idle cycles between them.
- Run accepted at T:
  - `sel_out` = 11 from T+1.
  - Processor done falls at T+2.
  - Done rises at cycle X: `sel_out` = 00 in X, `run_done_out` pulses at X+1, `busy_out` is low at X+1.
- `run_cycles_out` is valid from the `run_done_out` cycle and holds until the next run accept.

## Test plan

- Reset: hold `rst_n`=0 for 3 cycles mid-SHIFT → `sel_out`=00, `mosi_out`=0, `cmd_ready_out`=1 on the first cycle after release.
- Instruction write, addr=4'h3, data=8'hA5: `mosi_out` sequence 1,1,0,0,1,0,1,0,0,1,0,1 with `sel_out`=01 for 12 cycles, then 00. Processor icache[3]=8'hA5.
- Data write, addr=4'hF, data=8'h81, immediately followed by a second data write, addr=4'h0, data=8'h7E: the two frames are 14 cycles apart. Processor dcache[15]=8'h81 and dcache[0]=8'h7E.
- Run a 16-instruction program with no taken branches: `proc_done_in` low for 16 cycles → `run_cycles_out`=16, one `run_done_out` pulse, `run_timeout_out`=0. `sel_out` is 00 in the cycle done rises, and pc/acc show no extra execution.
- Run a program with an infinite `bnez` loop, `RUN_MAX`=100 → `run_done_out` and `run_timeout_out` pulse together after 100 cycles. `sel_out`=00 afterwards, and the processor returns to done=1.
- Hold `cmd_valid_in` high with op 11 → accepted each cycle, `busy_out` stays 0, `sel_out` stays 00.
